// File: rtl/serial_subtractor.sv
// Bit-serial A - B - borrow_in, LSB first, one full-subtractor cell; start->done in WIDTH cycles.
// No backpressure: start is only taken in IDLE and ignored while busy or done.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res, res_nxt;
  logic [WIDTH:0]   res_cat;
  logic [CW-1:0]    cnt;
  logic             br, br_nxt, d, last;
  logic             a_msb, b_msb;

  assign d       = sa[0] ^ sb[0] ^ br;
  assign br_nxt  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  // Concatenate-and-drop keeps the MSB-ward shift legal for WIDTH=1.
  assign res_cat = {d, res};
  assign res_nxt = res_cat[WIDTH:1];
  assign last    = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            br    <= borrow_in;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_nxt;
          br  <= br_nxt;
          cnt <= cnt + CW'(1);
          // Visible results only change on the final bit so they hold during RUN.
          if (last) begin
            diff       <= res_nxt;
            borrow_out <= br_nxt;
            overflow   <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances against an arithmetic reference model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, bin8, busy8, done8, bo8, ov8;
  logic [7:0] a8, b8, diff8;
  logic       start1, a1, b1, bin1, busy1, done1, diff1, bo1, ov1;

  int errors = 0;
  int checks = 0;

  logic [7:0] dir_a   [5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
  logic [7:0] dir_b   [5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
  logic       dir_bin [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] dir_d   [5] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80};
  logic       dir_bo  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       dir_ov  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1), .overflow(ov1)
  );

  // Reference: modular difference, unsigned compare for borrow, sign rule on the operands.
  function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b,
                                input logic bin, output logic [7:0] d, output logic bo,
                                output logic ov);
    int mask, ai, bi;
    mask = (1 << w) - 1;
    ai   = int'(a) & mask;
    bi   = int'(b) & mask;
    d    = 8'((ai - bi - int'(bin)) & mask);
    bo   = (ai < bi + int'(bin));
    ov   = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
  endfunction

  task automatic do_op(input bit w1, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output int lat, output int bcnt, output logic [7:0] d,
                       output logic bo, output logic ov, output logic dafter);
    @(negedge clk);
    if (w1) begin
      start1 = 1'b1; a1 = a[0]; b1 = b[0]; bin1 = bin;
    end else begin
      start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    end
    @(posedge clk); #1;
    start1 = 1'b0;
    start8 = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!(w1 ? done1 : done8) && lat < 40) begin
      if (w1 ? busy1 : busy8) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    d  = w1 ? {7'b0, diff1} : diff8;
    bo = w1 ? bo1 : bo8;
    ov = w1 ? ov1 : ov8;
    @(posedge clk); #1;
    dafter = w1 ? done1 : done8;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got %b exp 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8 got %b exp 0", done8); end
    checks++; if (diff8 !== 8'h00) begin errors++; $display("FAIL reset_diff8 got %h exp 00", diff8); end
    checks++; if ({bo8, ov8} !== 2'b00) begin errors++; $display("FAIL reset_bo_ov8 got %b exp 00", {bo8, ov8}); end
    checks++; if ({busy1, done1, diff1, bo1, ov1} !== 5'b0) begin
      errors++; $display("FAIL reset_w1 got %b exp 00000", {busy1, done1, diff1, bo1, ov1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    int lat, bcnt;
    logic [7:0] d;
    logic bo, ov, da;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, dir_a[i], dir_b[i], dir_bin[i], lat, bcnt, d, bo, ov, da);
      checks++; if (lat != 8) begin errors++; $display("FAIL dir%0d_latency got %0d exp 8", i, lat); end
      checks++; if (bcnt != 8) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d exp 8", i, bcnt); end
      checks++; if (d !== dir_d[i]) begin errors++; $display("FAIL dir%0d_diff got %h exp %h", i, d, dir_d[i]); end
      checks++; if (bo !== dir_bo[i]) begin errors++; $display("FAIL dir%0d_borrow got %b exp %b", i, bo, dir_bo[i]); end
      checks++; if (ov !== dir_ov[i]) begin errors++; $display("FAIL dir%0d_overflow got %b exp %b", i, ov, dir_ov[i]); end
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width got %b exp 0", i, da); end
    end
  endtask

  task automatic test_random;
    int lat, bcnt;
    logic [7:0] a, b, d, ed;
    logic bin, bo, ov, da, ebo, eov;
    for (int i = 0; i < 40; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      bin = 1'($urandom_range(0, 1));
      model(8, a, b, bin, ed, ebo, eov);
      do_op(1'b0, a, b, bin, lat, bcnt, d, bo, ov, da);
      checks++; if (lat != 8) begin errors++; $display("FAIL rnd%0d_latency got %0d exp 8", i, lat); end
      checks++; if ({d, bo, ov} !== {ed, ebo, eov}) begin
        errors++;
        $display("FAIL rnd%0d_result a=%h b=%h bin=%b got d=%h bo=%b ov=%b exp d=%h bo=%b ov=%b",
                 i, a, b, bin, d, bo, ov, ed, ebo, eov);
      end
    end
  endtask

  task automatic test_ignore_start;
    int ndone, dcyc;
    logic [7:0] dgot;
    ndone = 0; dcyc = -1; dgot = '0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        dcyc = cyc;
        dgot = diff8;
      end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ign_done_count got %0d exp 1", ndone); end
    checks++; if (dcyc != 8) begin errors++; $display("FAIL ign_done_edge got %0d exp 8", dcyc); end
    checks++; if (dgot !== 8'h0F) begin errors++; $display("FAIL ign_diff got %h exp 0f", dgot); end
  endtask

  task automatic test_reset_midrun;
    int nd, lat, bcnt;
    logic [7:0] d;
    logic bo, ov, da;
    nd = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy8, done8, bo8, ov8} !== 4'b0) begin
      errors++; $display("FAIL midrst_flags got %b exp 0000", {busy8, done8, bo8, ov8});
    end
    checks++; if (diff8 !== 8'h00) begin errors++; $display("FAIL midrst_diff got %h exp 00", diff8); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done8) nd++;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL midrst_spurious_done got %0d exp 0", nd); end
    do_op(1'b0, 8'h09, 8'h04, 1'b0, lat, bcnt, d, bo, ov, da);
    checks++; if (lat != 8) begin errors++; $display("FAIL midrst_latency got %0d exp 8", lat); end
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL midrst_diff_after got %h exp 05", d); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ta [30];
    logic [7:0] tb [30];
    logic       tbin [30];
    logic [7:0] ed;
    logic ebo, eov;
    int nd, idx;
    nd = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      ta[cyc]   = 8'($urandom);
      tb[cyc]   = 8'($urandom);
      tbin[cyc] = 1'($urandom_range(0, 1));
      start8 = 1'b1; a8 = ta[cyc]; b8 = tb[cyc]; bin8 = tbin[cyc];
      @(posedge clk); #1;
      if (done8) begin
        nd++;
        checks++;
        if (cyc % 10 != 8) begin
          errors++; $display("FAIL b2b_done_edge got %0d exp 8 mod 10", cyc);
        end else begin
          idx = cyc - 8;
          model(8, ta[idx], tb[idx], tbin[idx], ed, ebo, eov);
          checks++;
          if ({diff8, bo8, ov8} !== {ed, ebo, eov}) begin
            errors++;
            $display("FAIL b2b_result edge=%0d got d=%h bo=%b ov=%b exp d=%h bo=%b ov=%b",
                     cyc, diff8, bo8, ov8, ed, ebo, eov);
          end
        end
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    checks++; if (nd != 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", nd); end
  endtask

  task automatic test_width1;
    int lat, bcnt;
    logic [7:0] a, b, d, ed;
    logic bin, bo, ov, da, ebo, eov;
    for (int i = 0; i < 8; i++) begin
      a   = {7'b0, i[0]};
      b   = {7'b0, i[1]};
      bin = i[2];
      model(1, a, b, bin, ed, ebo, eov);
      do_op(1'b1, a, b, bin, lat, bcnt, d, bo, ov, da);
      checks++; if (lat != 1) begin errors++; $display("FAIL w1_%0d_latency got %0d exp 1", i, lat); end
      checks++; if (bcnt != 1) begin errors++; $display("FAIL w1_%0d_busy got %0d exp 1", i, bcnt); end
      checks++; if ({d[0], bo, ov} !== {ed[0], ebo, eov}) begin
        errors++;
        $display("FAIL w1_%0d_result a=%b b=%b bin=%b got %b exp %b",
                 i, a[0], b[0], bin, {d[0], bo, ov}, {ed[0], ebo, eov});
      end
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL w1_%0d_done_width got %b exp 0", i, da); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor computing A − B − borrow_in over WIDTH clock cycles, LSB first, using a single full-subtractor cell and a registered borrow. It generalises the combinational half subtractor to arbitrary operand width, a chainable borrow input, signed-overflow detection and a start/done handshake. It sits beside the combinational arithmetic cells as the area-minimal option for datapaths that can tolerate multi-cycle latency.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1–64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled with start.
- b  input  WIDTH  subtrahend; sampled with start.
- borrow_in  input  1  initial borrow; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle completion pulse.
- diff  output  WIDTH  result (a − b − borrow_in) mod 2^WIDTH.
- borrow_out  output  1  final borrow; set when the unsigned a < b + borrow_in.
- overflow  output  1  signed overflow of the subtraction.

## Operation
- The reset is synchronous and active-low. It is applied at any rising edge with rst_n=0 and takes priority over everything else.
  - State returns to IDLE.
  - busy, done, diff, borrow_out, overflow, the shift registers, the bit counter and the borrow flop are all cleared to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch a, b into shift registers; load borrow_in into the borrow flop; clear the counter. Go to RUN.
- RUN: each cycle processes bit i (shift-register LSB):
  - d = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d shifts into the result register MSB-ward. Operand registers shift right. Counter increments.
  - When the counter reaches WIDTH−1, that edge is the last bit. Go to DONE, and update diff, borrow_out = br' and overflow in the same edge.
- overflow = (a[WIDTH−1] != b[WIDTH−1]) && (diff[WIDTH−1] != a[WIDTH−1]), using the latched operands.
  - borrow_in is included in diff but does not otherwise modify this rule.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing, no error flag.
- diff, borrow_out and overflow hold their values until the next completion or reset. They do not change during RUN.
- WIDTH=1: a single RUN cycle. With borrow_in=0 the result equals the half subtractor truth table.
- The counter is sized clog2(WIDTH)+1 bits so WIDTH=1 and powers of two need no special case.

## Timing
- Edge E0: start sampled high in IDLE.
- Edges E1..E_WIDTH: one bit processed per edge.
- busy is high from after E0 until E_WIDTH.
- After E_WIDTH: done=1 and results valid. After E_WIDTH+1: IDLE, done=0.
- Latency: start edge to done high is WIDTH edges.
- Minimum issue interval: WIDTH+2 cycles. start may be high in the cycle done is high, but it is only accepted at the following IDLE edge, i.e. it must still be high then.
- Reset asserted during RUN or DONE:
  - the operation is discarded with no done pulse;
  - outputs read 0 after the reset edge;
  - start is accepted on the first edge with rst_n=1 in IDLE.
- start held continuously high: back-to-back operations, each using the operands sampled at its own IDLE edge.

## Test plan
- WIDTH=8, a=0x05, b=0x03, borrow_in=0 -> done exactly 8 edges after the start edge; diff=0x02, borrow_out=0, overflow=0; busy high for 8 cycles.
- WIDTH=8, a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1, overflow=0. Then a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1, overflow=0.
- WIDTH=8, a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
- WIDTH=8: pulse start with a=0x10, b=0x01, then pulse start again at cycle 3 with a=0xFF, b=0x00 -> second start ignored; result diff=0x0F; exactly one done pulse.
- WIDTH=8: start a=0xAA, b=0x55, then drop rst_n for one edge at cycle 4 -> all outputs 0, no done. A new start with a=0x09, b=0x04 gives diff=0x05 after 8 edges.
- WIDTH=1, borrow_in=0, exhaustive (a,b) -> (diff,borrow_out): (0,0)->(0,0), (1,0)->(1,0), (0,1)->(1,1), (1,1)->(0,0). Each completes in 1 RUN cycle with a done pulse.
